// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: format coding (identical to the
// extender's decode), opcodes used when building instruction templates, and
// the per-format legality checks.
package imm_encoder_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // An immediate fits when every bit above the format's sign bit copies it.
  function automatic logic imm_out_of_range(input logic [1:0] src, input logic [31:0] imm);
    logic oor;
    case (src)
      IMM_I, IMM_S: oor = !((&imm[31:11]) || !(|imm[31:11]));
      IMM_B:        oor = !((&imm[31:12]) || !(|imm[31:12]));
      IMM_J:        oor = !((&imm[31:20]) || !(|imm[31:20]));
      default:      oor = 1'b0;
    endcase
    return oor;
  endfunction

  // Branch and jump targets are halfword offsets, so bit 0 must be clear.
  function automatic logic imm_misaligned(input logic [1:0] src, input logic [31:0] imm);
    logic mis;
    case (src)
      IMM_B, IMM_J: mis = imm[0];
      default:      mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters immediate bits into the field positions of the
// selected format; every other bit of the word comes from the template.
// Only imm[20:0] is needed, the widest field (J) tops out at bit 20.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [1:0]  imm_src_i,
  input  logic [20:0] imm_i,
  input  logic [31:0] base_i,
  output logic [31:0] word_o
);

  // Overlay the immediate field onto the template for the chosen format.
  always_comb begin
    word_o = base_i;
    case (imm_src_i)
      IMM_I: begin
        word_o[31:20] = imm_i[11:0];
      end
      IMM_S: begin
        word_o[31:25] = imm_i[11:5];
        word_o[11:7]  = imm_i[4:0];
      end
      IMM_B: begin
        word_o[31]    = imm_i[12];
        word_o[30:25] = imm_i[10:5];
        word_o[11:8]  = imm_i[4:1];
        word_o[7]     = imm_i[11];
      end
      IMM_J: begin
        word_o[31]    = imm_i[20];
        word_o[30:21] = imm_i[10:1];
        word_o[20]    = imm_i[11];
        word_o[19:12] = imm_i[19:12];
      end
      default: begin
        word_o = base_i;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder. Stage 1 captures the request and
// its legality flags, stage 2 holds the packed word. Saturating counters track
// consumed results and consumed results carrying an error flag.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       imm_src,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_out,
  output logic             err_range,
  output logic             err_align,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage 1 keeps only imm[20:0]; upper bits matter solely for the range flag,
  // which is already resolved when the request is captured.
  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_src_q;
  logic [20:0]      s1_imm_q;
  logic [31:0]      s1_base_q;
  logic             s1_erng_q;
  logic             s1_eal_q;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      instr_q;
  logic             err_range_q;
  logic             err_align_q;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             s2_free;
  logic             accept;
  logic             advance;
  logic             consume;
  logic [31:0]      packed_word;

  imm_pack u_pack (
    .imm_src_i (s1_src_q),
    .imm_i     (s1_imm_q),
    .base_i    (s1_base_q),
    .word_o    (packed_word)
  );

  // Handshake qualifiers: stage 2 frees when empty or drained, stage 1 when it can move on.
  always_comb begin
    s2_free  = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_free;
    accept   = in_valid && in_ready;
    advance  = s1_valid_q && s2_free;
    consume  = out_valid_q && out_ready;
  end

  // Next-state of both valid bits and the saturating counters.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
      end else if (s2_free) begin
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = s1_valid_q;
      end
      if (s2_free) begin
        out_valid_d = s1_valid_q;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
    // A result drained in the flush cycle still reached the consumer, so it counts.
    if (consume && (enc_count_q != CNT_MAX)) begin
      enc_count_d = enc_count_q + CNT_ONE;
    end else begin
      enc_count_d = enc_count_q;
    end
    if (consume && (err_range_q || err_align_q) && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_ONE;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Valid bits and counters; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      enc_count_q <= {CNT_W{1'b0}};
      err_count_q <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  // Stage 1 payload: capture the request and resolve its flags on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_src_q  <= 2'b00;
      s1_imm_q  <= 21'd0;
      s1_base_q <= 32'd0;
      s1_erng_q <= 1'b0;
      s1_eal_q  <= 1'b0;
    end else if (accept) begin
      s1_src_q  <= imm_src;
      s1_imm_q  <= imm[20:0];
      s1_base_q <= base;
      s1_erng_q <= imm_out_of_range(imm_src, imm);
      s1_eal_q  <= imm_misaligned(imm_src, imm);
    end
  end

  // Stage 2 payload: take the packed word and flags when stage 1 hands over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q     <= 32'd0;
      err_range_q <= 1'b0;
      err_align_q <= 1'b0;
    end else if (advance) begin
      instr_q     <= packed_word;
      err_range_q <= s1_erng_q;
      err_align_q <= s1_eal_q;
    end
  end

  assign out_valid = out_valid_q;
  assign instr_out = instr_q;
  assign err_range = err_range_q;
  assign err_align = err_align_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate extender: packs a 32-bit signed immediate into the I/S/B/J bit positions of a RISC-V instruction word. Non-immediate fields (opcode, rd, rs1, rs2, funct) come from a base word.
- Flags immediates that are out of range or misaligned for the chosen format.
- Two-stage valid/ready pipeline. Feeds the instruction-memory loader and self-test generator.
- Round-trip property: extending the encoded word returns the original immediate for every legal input.

Parameters:
CNT_W, 16, width of saturating encoded-count and error-count registers

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of both pipeline stages
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request this cycle
imm_src  input  2  format: 00 I, 01 S, 10 B, 11 J (same coding as the extender)
imm  input  32  signed immediate (byte offset for B/J)
base  input  32  instruction template; bits in the immediate field are ignored
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
instr_out  output  32  packed instruction
err_range  output  1  immediate does not fit the format
err_align  output  1  B/J immediate has bit 0 set
enc_count  output  CNT_W  accepted results, saturating
err_count  output  CNT_W  accepted results with any error flag, saturating

Behaviour:
- Reset (async): s1_valid=0, out_valid=0, instr_out=0, err_range=0, err_align=0, enc_count=0, err_count=0.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free (combinational).
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - Stalled data holds stable; no drop, no duplicate.
- Latency: accept in cycle N gives out_valid in cycle N+2 with no backpressure. Throughput is 1 per cycle.
- Stage 1 registers imm_src, imm, base and computes flags:
  - Range, I/S: imm[31:11] not all equal → err_range.
  - Range, B: imm[31:12] not all equal → err_range.
  - Range, J: imm[31:20] not all equal → err_range.
  - err_align = imm[0] for B/J; always 0 for I/S.
- Stage 2 packs the word. All bits not listed come from base:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Error cases: the word is still packed from the truncated bits and the flags travel with it. Imm bit 0 is dropped for B/J.
- Counters:
  - enc_count increments on each output consumption.
  - err_count increments when the consumed result has err_range || err_align.
  - Both saturate at all-ones; neither wraps.
- flush: next edge clears s1_valid and out_valid; counters unaffected. If flush and in_valid are high together, the input is discarded; in_ready still follows the rule above.
- Simultaneous consume and accept: when stage 2 is full and out_ready=1, stage 2 takes stage 1 and stage 1 takes the new input in the same edge.
- Reset mid-transfer drops all in-flight data; no partial output.
- out_valid, instr_out, err_range and err_align all come from registers; no combinational path from input to output.

Decomposition:
- Shared package holds:
  - Format constants IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11, shared with the extender's decode.
  - Opcode constants used by the tests (OP_IMM, STORE, BRANCH, JAL).
- One natural sub-module, imm_pack: combinational packer of (imm_src, imm, base) → word, reusable by the bench as a reference.
- Handshake, range check and counters stay in the top module.

Test Plan:
- I-type, base=0x00000013, imm=0xFFFFFFFF (-1) → instr_out=0xFFF00013, no flags, 2-cycle latency.
- S-type, base=0x00002023, imm=8 → 0x00002423. B-type, base=0x00000063, imm=-4 → 0xFE000EE3.
- J-type, base=0x0000006F, imm=0x800 → 0x0010006F. J with imm=0x00100000 → err_range=1, err_count=1.
- B imm=3 → err_align=1. I imm=2048 → err_range=1. I imm=-2048 → no flag, field 0x800.
- out_ready low 5 cycles with 3 requests offered → in_ready drops after 2 accepted, outputs stay stable, then 3 results drain in order. flush mid-stream clears both stages.
- Random round trip over 10k vectors: extender(instr_out, imm_src) == imm whenever no flag is set. With CNT_W=2, 5 results → enc_count holds at 3.
